muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, fed by the ID/EX register alongside the ALU. Takes two 32-bit operands and a `muldiv_funct3_t` operation. It computes the result over multiple cycles with a start/busy/done handshake. The hazard logic holds the pipeline while the unit is busy. Its result goes to `alu_out` of the EX/MEM register for M-extension instructions.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `kill`  in  1  pipeline flush; aborts the operation in flight.
- `funct3`  in  3 (`muldiv_funct3_t`)  operation: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- `a`  in  32  rs1 value (dividend or multiplicand).
- `b`  in  32  rs2 value (divisor or multiplier).
- `busy`  out  1  high while an accepted operation is not yet done.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  32  final value; held until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIN, DONE.
- Accept: `start`=1 in IDLE or DONE with `kill`=0.
  - Latch `funct3`.
  - Latch |a| and |b| per signedness: a is signed for mulh, mulhsu, div, rem; b is signed for mulh, div, rem.
  - Latch the expected result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Clear the 6-bit `count`.
- Special cases, decided at accept; go straight to DONE with `result` loaded:
  - div/divu with b=0 → 0xFFFFFFFF.
  - rem/remu with b=0 → a.
  - div with a=0x80000000, b=0xFFFFFFFF → 0x80000000.
  - rem with the same operands → 0.
- CALC, multiply: 64-bit unsigned shift-add, one multiplier bit per cycle, 32 cycles.
- CALC, divide: restoring division, one quotient bit per cycle, 32 cycles.
  - 33-bit partial remainder.
  - Trial subtract of the divisor; keep the difference if non-negative.
- CALC → FIN when `count`=31 at the clock edge.
- FIN:
  - Two's-complement the 64-bit product, quotient or remainder if the latched sign is 1.
  - Select the result: low word for mul; high word for mulh/mulhsu/mulhu; quotient for div/divu; remainder for rem/remu.
  - Load `result`; go to DONE.
- DONE: `done`=1 for one cycle.
  - → CALC if a new `start` is accepted (or → DONE again on a special case).
  - Otherwise → IDLE.
- `busy` = 1 in CALC and FIN, and in the IDLE/DONE cycle that accepts a `start`, so the stall is combinational.
- `kill`: in any state, next state = IDLE with `done`=0. `result` keeps its last value. A `start` in the same cycle as `kill` is ignored.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `count`=0, all datapath registers 0.
- Reset asserted mid-operation aborts it immediately; no `done` follows.
- Normal latency: `start` accepted in cycle 0 → CALC in cycles 1–32 → FIN in cycle 33 → `done` in cycle 34.
- Special-case latency: `done` in cycle 1.
- Throughput: a new `start` may be accepted in the DONE cycle, so back-to-back normal operations complete every 34 cycles.
- `result` changes only at the FIN→DONE edge or at a special-case accept edge.
- `a` and `b` may change freely after the accept edge.

## Structure
- Reuse `muldiv_funct3_t` and `rv32i_word` from `rv32i_types`.
- Add `muldiv_state_t` (IDLE, CALC, FIN, DONE) to `rv32i_types` so the hazard unit and bench can decode it.
- Single module, no sub-module.
- Datapath registers: 64-bit accumulator/remainder, 32-bit operand, 6-bit `count`, sign flags.

## Test plan
- mul, a=7, b=0xFFFFFFFD, start in cycle 0 → `busy` high cycles 0–33, `done` in cycle 34, `result`=0xFFFFFFEB.
- High-word multiplies:
  - mulh 0x80000000 × 0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - mulhsu a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- Signed and unsigned divide:
  - div −7/2 → 0xFFFFFFFD.
  - rem −7/2 → 0xFFFFFFFF.
  - divu 7/2 → 3.
  - remu 0xFFFFFFFF/0x10 → 0xF.
- Special cases, each with `done` in cycle 1:
  - div 5/0 → 0xFFFFFFFF.
  - remu 5/0 → 5.
  - div 0x80000000/−1 → 0x80000000.
  - rem 0x80000000/−1 → 0.
- Kill and reset:
  - `kill` in cycle 10 of a mul → no `done`; `busy`=0 in cycle 11; `result` unchanged; a following divu 100/7 returns 14 on schedule.
  - `rst` pulsed in cycle 5 → all outputs return to their reset values immediately.
- Back-to-back: second `start` (mul 3×5) in the DONE cycle of the first operation → `done` 34 cycles later with `result`=15; no IDLE cycle between the two.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32 types for the EX stage: data word, M-extension funct3 encodings
// and the multiply/divide FSM state so the hazard unit can decode it.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011,
        div    = 3'b100,
        divu   = 3'b101,
        rem    = 3'b110,
        remu   = 3'b111
    } muldiv_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10,
        DONE = 2'b11
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 34-cycle start-to-done (1 cycle for div-by-zero/overflow).
// No backpressure: busy stalls the pipeline combinationally; kill aborts to IDLE.
module muldiv_unit
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  muldiv_funct3_t  funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t  r_state;
    muldiv_state_t  w_next;
    muldiv_funct3_t r_funct3;
    logic [63:0]    r_acc;
    logic [31:0]    r_opb;
    logic [5:0]     r_count;
    logic           r_neg;
    rv32i_word      r_result;

    logic       w_accept;
    logic       w_sign_a, w_sign_b, w_neg_a, w_neg_b, w_res_neg;
    rv32i_word  w_abs_a, w_abs_b;
    logic       w_div0, w_ovf, w_special;
    rv32i_word  w_special_res;

    assign w_sign_a  = funct3 inside {mulh, mulhsu, div, rem};
    assign w_sign_b  = funct3 inside {mulh, div, rem};
    assign w_neg_a   = w_sign_a & a[31];
    assign w_neg_b   = w_sign_b & b[31];
    assign w_abs_a   = w_neg_a ? -a : a;
    assign w_abs_b   = w_neg_b ? -b : b;
    // Remainder takes the dividend's sign; product and quotient take sa^sb.
    assign w_res_neg = (funct3 inside {rem, remu}) ? w_neg_a : (w_neg_a ^ w_neg_b);

    assign w_div0    = funct3[2] & (b == 32'h0);
    assign w_ovf     = (funct3 inside {div, rem}) & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
    assign w_special = w_div0 | w_ovf;
    assign w_special_res = w_div0 ? (funct3[1] ? a : 32'hFFFF_FFFF)
                                  : (funct3[1] ? 32'h0 : 32'h8000_0000);

    assign w_accept = start & ~kill & ((r_state == IDLE) | (r_state == DONE));

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done   = (r_state == DONE);
                busy   = w_accept;
                w_next = w_accept ? (w_special ? DONE : CALC) : IDLE;
            end
            CALC: begin
                busy = 1'b1;
                if (r_count == 6'd31) w_next = FIN;
            end
            FIN: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
        if (kill) begin
            w_next = IDLE;
            done   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Multiply: acc = {partial product high, remaining multiplier bits}, shift right.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_step;
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    assign w_mul_step = {w_mul_sum, r_acc[31:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shift left.
    logic [32:0] w_div_part, w_div_diff;
    logic [63:0] w_div_step;
    assign w_div_part = r_acc[63:31];
    assign w_div_diff = w_div_part - {1'b0, r_opb};
    assign w_div_step = w_div_diff[32] ? {w_div_part[31:0], r_acc[30:0], 1'b0}
                                       : {w_div_diff[31:0], r_acc[30:0], 1'b1};

    logic [63:0] w_prod_fin;
    rv32i_word   w_quo_fin, w_rem_fin, w_fin_res;
    assign w_prod_fin = r_neg ? -r_acc : r_acc;
    assign w_quo_fin  = r_neg ? -r_acc[31:0]  : r_acc[31:0];
    assign w_rem_fin  = r_neg ? -r_acc[63:32] : r_acc[63:32];
    assign w_fin_res  = (r_funct3 == mul) ? w_prod_fin[31:0]  :
                        !r_funct3[2]      ? w_prod_fin[63:32] :
                        r_funct3[1]       ? w_rem_fin : w_quo_fin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_funct3 <= mul;
            r_acc    <= '0;
            r_opb    <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_funct3 <= funct3;
            r_neg    <= w_res_neg;
            r_count  <= '0;
            r_acc    <= {32'h0, funct3[2] ? w_abs_a : w_abs_b};
            r_opb    <= funct3[2] ? w_abs_b : w_abs_a;
            if (w_special) r_result <= w_special_res;
        end else if (r_state == CALC && !kill) begin
            r_acc   <= r_funct3[2] ? w_div_step : w_mul_step;
            r_count <= r_count + 6'd1;
        end else if (r_state == FIN && !kill) begin
            r_result <= w_fin_res;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, special cases, kill/reset, back-to-back.
module tb_muldiv_unit;
    import rv32i_types::*;

    logic           clk    = 1'b0;
    logic           rst    = 1'b1;
    logic           start  = 1'b0;
    logic           kill   = 1'b0;
    muldiv_funct3_t funct3 = mul;
    rv32i_word      a      = '0;
    rv32i_word      b      = '0;
    logic           busy, done;
    rv32i_word      result;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Starts an op (caller is just after a rising edge) and waits, bounded, for done.
    task automatic do_op(input muldiv_funct3_t f, input rv32i_word av, input rv32i_word bv,
                         output int lat, output rv32i_word res);
        funct3 = f; a = av; b = bv; start = 1'b1;
        lat = -1; res = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) begin lat = c; res = result; end
            @(posedge clk); #1;
            start = 1'b0; a = 32'h5A5A_5A5A; b = 32'h0;
            if (lat >= 0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_mul_timing();
        funct3 = mul; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
        for (int c = 0; c <= 34; c++) begin
            @(negedge clk);
            checks++; if (busy !== (c <= 33)) begin failures++; $display("FAIL mul_busy c=%0d got=%b exp=%b", c, busy, c <= 33); end
            checks++; if (done !== (c == 34)) begin failures++; $display("FAIL mul_done c=%0d got=%b exp=%b", c, done, c == 34); end
            if (c == 34) begin
                checks++; if (result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", result); end
            end
            @(posedge clk); #1;
            start = 1'b0; a = 32'h1234_5678; b = 32'h0;
        end
    endtask

    muldiv_funct3_t v_f[13] = '{mulh, mulhu, mulhsu, div, rem, divu, remu, divu, remu,
                                div, remu, div, rem};
    rv32i_word v_a[13] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                           32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                           32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    rv32i_word v_b[13] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                           32'd2, 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    rv32i_word v_r[13] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                           32'd3, 32'hF, 32'h0, 32'h8000_0000,
                           32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    int        v_l[13] = '{34, 34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};

    task automatic test_ops();
        int        lat;
        rv32i_word res;
        for (int i = 0; i < 13; i++) begin
            do_op(v_f[i], v_a[i], v_b[i], lat, res);
            checks++; if (lat !== v_l[i]) begin failures++; $display("FAIL op%0d_latency got=%0d exp=%0d", i, lat, v_l[i]); end
            checks++; if (res !== v_r[i]) begin failures++; $display("FAIL op%0d_result got=%h exp=%h", i, res, v_r[i]); end
            @(negedge clk);
            checks++; if (result !== v_r[i]) begin failures++; $display("FAIL op%0d_held got=%h exp=%h", i, result, v_r[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_kill();
        rv32i_word prev;
        int        lat, ndone;
        rv32i_word res;
        prev = result;
        funct3 = mul; a = 32'd5; b = 32'd6; start = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c == 11) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL kill_busy got=%b exp=0", busy); end
                checks++; if (done !== 1'b0) begin failures++; $display("FAIL kill_done got=%b exp=0", done); end
            end
            @(posedge clk); #1;
            start = 1'b0;
            kill  = (c + 1 == 10);
        end
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL kill_no_done got=%0d exp=0", ndone); end
        checks++; if (result !== prev) begin failures++; $display("FAIL kill_result_kept got=%h exp=%h", result, prev); end
        @(posedge clk); #1;
        do_op(divu, 32'd100, 32'd7, lat, res);
        checks++; if (lat !== 34) begin failures++; $display("FAIL after_kill_latency got=%0d exp=34", lat); end
        checks++; if (res !== 32'd14) begin failures++; $display("FAIL after_kill_result got=%h exp=0000000e", res); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        funct3 = mul; a = 32'd9; b = 32'd9; start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL rst_mid_result got=%h exp=00000000", result); end
        @(posedge clk); #1; rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL rst_mid_quiet got=%0d exp=0", ndone); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        funct3 = divu; a = 32'd7; b = 32'd2; start = 1'b1;
        for (int c = 0; c <= 68; c++) begin
            @(negedge clk);
            checks++; if (busy !== (c <= 67)) begin failures++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy, c <= 67); end
            checks++; if (done !== (c == 34 || c == 68)) begin failures++; $display("FAIL b2b_done c=%0d got=%b", c, done); end
            if (c == 34) begin
                checks++; if (result !== 32'd3) begin failures++; $display("FAIL b2b_first_result got=%h exp=00000003", result); end
            end
            if (c == 68) begin
                checks++; if (result !== 32'd15) begin failures++; $display("FAIL b2b_second_result got=%h exp=0000000f", result); end
            end
            @(posedge clk); #1;
            if (c + 1 == 34) begin
                funct3 = mul; a = 32'd3; b = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0; a = 32'hFFFF_0000; b = 32'h0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_ops();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
